i2c_slave_regfile: RTL and testbench
====================================

I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h40, the 7-bit device address it answers.
REQ-002 SHALL have parameter REG_NUM, default 32, the register count: 8-bit registers, address width 5.
REQ-003 SHALL have port sys_clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port scl  input  1  I2C SCL, asynchronous to sys_clk.
REQ-006 SHALL have port sda_in  input  1  I2C SDA as seen on the pad.
REQ-007 SHALL have port sda_oe  output  1  1 pulls SDA low; 0 releases it (open drain, pad logic external).
REQ-008 SHALL have port wr_pulse  output  1  one-cycle strobe marking a register write.
REQ-009 SHALL have port wr_addr  output  5  address of the register written on wr_pulse.
REQ-010 SHALL have port wr_data  output  8  data of the register written on wr_pulse.
REQ-011 SHALL have port app_addr  input  5  application read address.
REQ-012 SHALL have port app_data  output  8  combinational read of regfile[app_addr].
REQ-013 SHALL have port busy  output  1  high from START until STOP while this slave is addressed.

Function
REQ-014 SHALL pass scl and sda_in through a 2-flop synchronizer each, then a 3rd flop for edge detection.
REQ-015 SHALL detect START as a synced SDA falling edge while synced SCL is high, and STOP as an SDA rising edge while SCL is high.
REQ-016 SHALL sample SDA on the synced SCL rising edge and SHALL change sda_oe only on the synced SCL falling edge.
REQ-017 SHALL use states IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK and WAIT_STOP.
REQ-018 SHALL go IDLE->DEV_ADDR on START; after 8 bits (MSB first, bit0 = R/W) SHALL go to DEV_ACK if the address matches, else WAIT_STOP with sda_oe=0.
REQ-019 SHALL drive ACK (sda_oe=1) for exactly one SCL period in every ACK state; R/W=0 leads to REG_ADDR, R/W=1 leads to RD_DATA.
REQ-020 SHALL take the REG_ADDR byte modulo REG_NUM as pointer ptr, ACK it, then enter WR_DATA.
REQ-021 SHALL, in WR_DATA, after each 8 bits assert wr_pulse for 1 sys_clk, write regfile[ptr], ACK, then set ptr=(ptr+1) mod REG_NUM.
REQ-022 SHALL, in RD_DATA, shift regfile[ptr] out MSB first by driving sda_oe=~bit, then release SDA and sample the master ACK; ptr increments after each byte.
REQ-023 SHALL, in RD_ACK, continue with the next byte on master ACK (SDA low) and go to WAIT_STOP on master NACK.
REQ-024 SHALL treat START in any state (repeated START) as abort: bit counter cleared, sda_oe=0, state DEV_ADDR, ptr retained.
REQ-025 SHALL treat STOP in any state as: sda_oe=0, state IDLE, busy=0; a partial byte is discarded and not written.
REQ-026 SHALL ensure ptr wraps 31->0 during both write and read bursts.
REQ-027 SHALL keep the regfile on a general-call address (7'h00) and not ACK it.

Reset
REQ-028 SHALL, on rst=1 at a sys_clk edge, set state IDLE, sda_oe=0, wr_pulse=0, wr_addr=0, wr_data=0, busy=0, ptr=0, and all registers and synchronizer flops to 1 (bus idle).
REQ-029 SHALL treat rst during a transfer as releasing SDA on the next cycle, with the remaining bus activity ignored until a new START.

Configuration
REQ-030 SHALL, when macro I2C_SLAVE_READ_EN is defined, implement RD_DATA/RD_ACK per REQ-022/023.
REQ-031 SHALL, when I2C_SLAVE_READ_EN is undefined, NACK a matching address with R/W=1 and go to WAIT_STOP; RD states SHALL be absent.

Verification
REQ-032 SHALL be verified by: write 0x80,0x03,0x11 -> ACK on 3 bytes; wr_pulse once with wr_addr=3 and wr_data=0x11; app_addr=3 gives 0x11.
REQ-033 SHALL be verified by: address 0x42 write -> no ACK, busy=0, regfile unchanged.
REQ-034 SHALL be verified by: burst write to reg 31 of 0xAA,0xBB -> regfile[31]=0xAA, regfile[0]=0xBB.
REQ-035 SHALL be verified by: write ptr=5, repeated START, 0x81, read 2 bytes ACK then NACK -> SDA returns regfile[5], regfile[6]; READ_EN undefined -> 0x81 NACKed.
REQ-036 SHALL be verified by: STOP after 4 data bits -> no wr_pulse, state IDLE, sda_oe=0.
REQ-037 SHALL be verified by: rst asserted during an ACK bit -> sda_oe=0 next cycle, ptr=0.

Source files
------------

// File: rtl/i2c_slave_regfile_if.sv
// rtl/i2c_slave_regfile_if.sv - bus bundle between an I2C register-file slave and its surroundings
//
// Purpose: groups the I2C pad signals, the register-write strobe and the
// application read port of i2c_slave_regfile into one interface.
//
// Signals:
//   scl       I2C SCL from the pad, asynchronous to the slave clock
//   sda_in    I2C SDA as seen on the pad
//   sda_oe    1 pulls SDA low, 0 releases it (open-drain pad outside)
//   wr_pulse  one-cycle strobe marking a register write
//   wr_addr   register address written on wr_pulse
//   wr_data   register data written on wr_pulse
//   app_addr  application read address
//   app_data  combinational read of the register at app_addr
//   busy      high while this slave is addressed, until STOP
//
// Modports: slave (used by the design), master (used by the environment).

interface i2c_slave_regfile_if;
    logic       scl;
    logic       sda_in;
    logic       sda_oe;
    logic       wr_pulse;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] app_addr;
    logic [7:0] app_data;
    logic       busy;

    modport slave (
        input  scl, sda_in, app_addr,
        output sda_oe, wr_pulse, wr_addr, wr_data, app_data, busy
    );

    modport master (
        output scl, sda_in, app_addr,
        input  sda_oe, wr_pulse, wr_addr, wr_data, app_data, busy
    );
endinterface

// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - I2C slave exposing a bank of 8-bit registers
//
// Purpose: 7-bit-addressed I2C slave. A write transaction sets a register
// pointer and then writes a burst of bytes with auto-increment (wrapping at
// REG_NUM). Reads are optional: with macro I2C_SLAVE_READ_EN defined the slave
// answers R/W=1 by shifting registers out from the pointer; without it a read
// request to this address is NACKed and ignored until STOP.
//
// Parameters:
//   SLAVE_ADDR  7-bit device address (default 7'h40); general call is never ACKed
//   REG_NUM     number of 8-bit registers (default 32, pointer width 5)
//
// Ports:
//   sys_clk  system clock, rising edge
//   rst      synchronous active-high reset
//   bus      i2c_slave_regfile_if.slave: scl, sda_in, sda_oe, wr_pulse,
//            wr_addr, wr_data, app_addr, app_data, busy
//
// Configuration macro: I2C_SLAVE_READ_EN (enables RD_DATA / RD_ACK).

module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h40,
    parameter int         REG_NUM    = 32
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    i2c_slave_regfile_if.slave    bus
);

    localparam int AW = 5;

`ifdef I2C_SLAVE_READ_EN
    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
        WR_DATA, WR_ACK, WAIT_STOP
    } state_t;
`endif

    state_t          r_state;
    logic [2:0]      r_scl_sync;   // [0],[1] synchronizer, [2] edge-detect history
    logic [2:0]      r_sda_sync;
    logic [7:0]      r_regs [REG_NUM];
    logic [AW-1:0]   r_ptr;
    logic [7:0]      r_shift;
    logic [3:0]      r_bit_cnt;
    logic            r_sda_oe;
    logic            r_wr_pulse;
    logic [AW-1:0]   r_wr_addr;
    logic [7:0]      r_wr_data;
    logic            r_busy;
`ifdef I2C_SLAVE_READ_EN
    logic [7:0]      r_tx;
    logic            r_rw;
`endif

    logic            w_scl;
    logic            w_scl_d;
    logic            w_sda;
    logic            w_sda_d;
    logic            w_scl_rise;
    logic            w_scl_fall;
    logic            w_start;
    logic            w_stop;
    logic            w_byte_done;
    logic            w_addr_match;
    logic [AW-1:0]   w_ptr_next;
    logic [AW-1:0]   w_reg_ptr;

    assign w_scl      = r_scl_sync[1];
    assign w_scl_d    = r_scl_sync[2];
    assign w_sda      = r_sda_sync[1];
    assign w_sda_d    = r_sda_sync[2];
    assign w_scl_rise = w_scl & ~w_scl_d;
    assign w_scl_fall = ~w_scl & w_scl_d;
    // SDA may only move while SCL is high for START/STOP; require SCL high on
    // both samples so an SCL edge coinciding with an SDA edge is not mistaken.
    assign w_start    = w_scl & w_scl_d & ~w_sda & w_sda_d;
    assign w_stop     = w_scl & w_scl_d & w_sda & ~w_sda_d;

    // A received byte is acted on at the SCL fall that ends its 8th bit, so
    // the ACK (or the first read bit) is put on SDA while SCL is low.
    assign w_byte_done  = w_scl_fall && (r_bit_cnt == 4'd8);
    assign w_addr_match = (r_shift[7:1] == SLAVE_ADDR) && (SLAVE_ADDR != 7'h00);
    assign w_ptr_next   = (r_ptr == AW'(REG_NUM - 1)) ? '0 : r_ptr + 1'b1;
    assign w_reg_ptr    = AW'(32'(r_shift) % REG_NUM);

    assign bus.sda_oe   = r_sda_oe;
    assign bus.wr_pulse = r_wr_pulse;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.busy     = r_busy;
    assign bus.app_data = r_regs[bus.app_addr];

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_sda_oe   <= 1'b0;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= 8'hFF;
            end
`ifdef I2C_SLAVE_READ_EN
            r_tx       <= '0;
            r_rw       <= 1'b0;
`endif
        end else begin
            r_scl_sync <= {r_scl_sync[1:0], bus.scl};
            r_sda_sync <= {r_sda_sync[1:0], bus.sda_in};
            r_wr_pulse <= 1'b0;

            if (w_start) begin
                // Repeated START aborts whatever was in flight; pointer survives
                // so a write of the register address can be followed by a read.
                r_state   <= DEV_ADDR;
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                    end

                    DEV_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_byte_done) begin
                            r_bit_cnt <= '0;
`ifdef I2C_SLAVE_READ_EN
                            if (w_addr_match) begin
                                r_rw     <= r_shift[0];
                                r_state  <= DEV_ACK;
                                r_sda_oe <= 1'b1;
                                r_busy   <= 1'b1;
                            end else begin
                                r_state  <= WAIT_STOP;
                                r_sda_oe <= 1'b0;
                                r_busy   <= 1'b0;
                            end
`else
                            if (w_addr_match && !r_shift[0]) begin
                                r_state  <= DEV_ACK;
                                r_sda_oe <= 1'b1;
                                r_busy   <= 1'b1;
                            end else begin
                                r_state  <= WAIT_STOP;
                                r_sda_oe <= 1'b0;
                                r_busy   <= 1'b0;
                            end
`endif
                        end
                    end

                    DEV_ACK: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= '0;
`ifdef I2C_SLAVE_READ_EN
                            if (r_rw) begin
                                r_tx     <= r_regs[r_ptr];
                                r_sda_oe <= ~r_regs[r_ptr][7];
                                r_state  <= RD_DATA;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= REG_ADDR;
                            end
`else
                            r_sda_oe <= 1'b0;
                            r_state  <= REG_ADDR;
`endif
                        end
                    end

                    REG_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_byte_done) begin
                            r_bit_cnt <= '0;
                            r_ptr     <= w_reg_ptr;
                            r_sda_oe  <= 1'b1;
                            r_state   <= REG_ACK;
                        end
                    end

                    REG_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_state  <= WR_DATA;
                        end
                    end

                    WR_DATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_byte_done) begin
                            r_bit_cnt      <= '0;
                            r_regs[r_ptr]  <= r_shift;
                            r_wr_pulse     <= 1'b1;
                            r_wr_addr      <= r_ptr;
                            r_wr_data      <= r_shift;
                            r_ptr          <= w_ptr_next;
                            r_sda_oe       <= 1'b1;
                            r_state        <= WR_ACK;
                        end
                    end

                    WR_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_state  <= WR_DATA;
                        end
                    end

`ifdef I2C_SLAVE_READ_EN
                    RD_DATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                // Byte done: release SDA for the master's ACK.
                                r_bit_cnt <= '0;
                                r_sda_oe  <= 1'b0;
                                r_ptr     <= w_ptr_next;
                                r_state   <= RD_ACK;
                            end else if (r_bit_cnt != 4'd0) begin
                                r_tx     <= {r_tx[6:0], 1'b0};
                                r_sda_oe <= ~r_tx[6];
                            end
                        end
                    end

                    RD_ACK: begin
                        if (w_scl_rise) begin
                            r_shift[0] <= w_sda;
                            r_bit_cnt  <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && (r_bit_cnt != 4'd0)) begin
                            r_bit_cnt <= '0;
                            if (!r_shift[0]) begin
                                r_tx     <= r_regs[r_ptr];
                                r_sda_oe <= ~r_regs[r_ptr][7];
                                r_state  <= RD_DATA;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= WAIT_STOP;
                            end
                        end
                    end
`endif

                    WAIT_STOP: begin
                    end

                    default: begin
                        r_state  <= IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb/tb_i2c_slave_regfile.sv - directed bench for i2c_slave_regfile
module tb_i2c_slave_regfile;

    logic sys_clk = 1'b0;
    logic rst;
    logic sda_m;

    i2c_slave_regfile_if bus();

    i2c_slave_regfile #(.SLAVE_ADDR(7'h40), .REG_NUM(32)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // Open-drain wired-AND of master and slave.
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;

    always @(negedge sys_clk) begin
        if (bus.wr_pulse === 1'b1) pulse_cnt++;
    end

    typedef struct {
        logic [7:0] dev;
        logic [7:0] rega;
        logic [7:0] data;
        logic       dev_ack;
        logic [4:0] chk_addr;
        logic [7:0] chk_data;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (20) @(negedge sys_clk);
    endtask

    task automatic check_reg(input string name, input logic [4:0] a, input logic [7:0] exp);
        bus.app_addr = a;
        #1;
        check(name, 32'(bus.app_data), 32'(exp));
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        bus.scl = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        bus.scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        bus.scl = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; wait_q();
        bus.scl = 1'b1; wait_q();
        bus.scl = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_q();
        bus.scl = 1'b1; wait_q();
        b = bus.sda_in;
        bus.scl = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int k = 7; k >= 0; k--) write_bit(d[k]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int k = 7; k >= 0; k--) begin
            read_bit(b);
            d[k] = b;
        end
        write_bit(~ack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         p0;

        vecs[0] = '{8'h80, 8'h03, 8'h11, 1'b1, 5'd3,  8'h11};
        vecs[1] = '{8'h84, 8'h03, 8'h55, 1'b0, 5'd3,  8'h11};
        vecs[2] = '{8'h00, 8'h04, 8'h66, 1'b0, 5'd4,  8'hFF};
        vecs[3] = '{8'h80, 8'h25, 8'h5A, 1'b1, 5'd5,  8'h5A};
        vecs[4] = '{8'h80, 8'h1F, 8'hC3, 1'b1, 5'd31, 8'hC3};

        rst = 1'b1;
        sda_m = 1'b1;
        bus.scl = 1'b1;
        bus.app_addr = 5'd0;
        repeat (3) @(negedge sys_clk);
        check("rst_sda_oe",   32'(bus.sda_oe),   0);
        check("rst_busy",     32'(bus.busy),     0);
        check("rst_wr_pulse", 32'(bus.wr_pulse), 0);
        check("rst_wr_addr",  32'(bus.wr_addr),  0);
        check("rst_wr_data",  32'(bus.wr_data),  0);
        check("rst_ptr",      32'(dut.r_ptr),    0);
        check_reg("rst_reg0", 5'd0, 8'hFF);
        rst = 1'b0;
        wait_q();

        for (int i = 0; i < 5; i++) begin
            p0 = pulse_cnt;
            i2c_start();
            write_byte(vecs[i].dev, ack);
            check($sformatf("v%0d_dev_ack", i), 32'(ack), 32'(vecs[i].dev_ack));
            check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vecs[i].dev_ack));
            write_byte(vecs[i].rega, ack);
            check($sformatf("v%0d_reg_ack", i), 32'(ack), 32'(vecs[i].dev_ack));
            write_byte(vecs[i].data, ack);
            check($sformatf("v%0d_data_ack", i), 32'(ack), 32'(vecs[i].dev_ack));
            check($sformatf("v%0d_ack_release", i), 32'(bus.sda_oe), 0);
            i2c_stop();
            wait_q();
            check($sformatf("v%0d_pulses", i), 32'(pulse_cnt - p0), vecs[i].dev_ack ? 1 : 0);
            check($sformatf("v%0d_busy_end", i), 32'(bus.busy), 0);
            if (vecs[i].dev_ack) begin
                check($sformatf("v%0d_wr_addr", i), 32'(bus.wr_addr), 32'(vecs[i].chk_addr));
                check($sformatf("v%0d_wr_data", i), 32'(bus.wr_data), 32'(vecs[i].data));
            end
            check_reg($sformatf("v%0d_app_data", i), vecs[i].chk_addr, vecs[i].chk_data);
        end

        // Burst write wrapping 31 -> 0.
        p0 = pulse_cnt;
        i2c_start();
        write_byte(8'h80, ack); check("burst_dev_ack", 32'(ack), 1);
        write_byte(8'h1F, ack); check("burst_reg_ack", 32'(ack), 1);
        write_byte(8'hAA, ack); check("burst_d0_ack", 32'(ack), 1);
        write_byte(8'hBB, ack); check("burst_d1_ack", 32'(ack), 1);
        i2c_stop();
        wait_q();
        check("burst_pulses", 32'(pulse_cnt - p0), 2);
        check("burst_wr_addr", 32'(bus.wr_addr), 0);
        check_reg("burst_reg31", 5'd31, 8'hAA);
        check_reg("burst_reg0",  5'd0,  8'hBB);

        // Preload regs 5/6, then pointer write + repeated START + read.
        i2c_start();
        write_byte(8'h80, ack);
        write_byte(8'h05, ack);
        write_byte(8'h3C, ack);
        write_byte(8'hE7, ack);
        i2c_stop();
        check_reg("pre_reg5", 5'd5, 8'h3C);
        check_reg("pre_reg6", 5'd6, 8'hE7);
        p0 = pulse_cnt;
        i2c_start();
        write_byte(8'h80, ack);
        write_byte(8'h05, ack); check("rd_ptr_ack", 32'(ack), 1);
        i2c_start();
        write_byte(8'h81, ack);
`ifdef I2C_SLAVE_READ_EN
        check("rd_dev_ack", 32'(ack), 1);
        read_byte(d, 1'b1); check("rd_byte0", 32'(d), 32'h3C);
        read_byte(d, 1'b0); check("rd_byte1", 32'(d), 32'hE7);
        check("rd_release", 32'(bus.sda_oe), 0);
`else
        check("rd_dev_nack", 32'(ack), 0);
        check("rd_nack_busy", 32'(bus.busy), 0);
`endif
        i2c_stop();
        wait_q();
        check("rd_pulses", 32'(pulse_cnt - p0), 0);
        check("rd_busy_end", 32'(bus.busy), 0);

        // STOP after 4 data bits discards the partial byte.
        p0 = pulse_cnt;
        i2c_start();
        write_byte(8'h80, ack);
        write_byte(8'h09, ack);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        wait_q();
        check("partial_pulses", 32'(pulse_cnt - p0), 0);
        check("partial_sda_oe", 32'(bus.sda_oe), 0);
        check("partial_busy",   32'(bus.busy), 0);
        check_reg("partial_reg9", 5'd9, 8'hFF);

        // Reset while the slave is driving the data ACK.
        i2c_start();
        write_byte(8'h80, ack);
        write_byte(8'h07, ack);
        for (int k = 7; k >= 0; k--) write_bit(k[0]);
        sda_m = 1'b1;
        wait_q();
        check("rstack_driving", 32'(bus.sda_oe), 1);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        check("rstack_sda_oe", 32'(bus.sda_oe), 0);
        check("rstack_ptr",    32'(dut.r_ptr),  0);
        check("rstack_busy",   32'(bus.busy),   0);
        bus.scl = 1'b1; wait_q();
        bus.scl = 1'b0; wait_q();
        write_bit(1'b1);
        check("rstack_ignored", 32'(bus.sda_oe), 0);
        i2c_stop();
        wait_q();
        check_reg("rstack_reg7", 5'd7, 8'hFF);

        // Recovery after reset.
        i2c_start();
        write_byte(8'h80, ack); check("recov_dev_ack", 32'(ack), 1);
        write_byte(8'h01, ack);
        write_byte(8'h77, ack); check("recov_data_ack", 32'(ack), 1);
        i2c_stop();
        wait_q();
        check_reg("recov_reg1", 5'd1, 8'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
